wb_stage_grf: RTL
=================

// Module: wb_stage_grf
// PURPOSE
//  Writeback stage plus general register file of the 5-stage MIPS pipeline.
//  Consumes MEM/WB register outputs: IR_W, ALUResult_W, pc8_W, DM_RD_W.
//  - Decodes IR_W.
//  - Extends sub-word loads.
//  - Selects the write-back value and writes the 32x32 GRF.
//  - Serves the decode stage's two read ports with same-cycle write bypass.
//  - Exports the W-stage write triple for hazard forwarding.
//  - Keeps a retired-instruction counter.
// PARAMETERS
//  NREG   32  number of architectural registers (register 0 is hard-wired to zero)
//  CNT_W  32  width of retire counter
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low reset
//  IR_W         in   32  instruction in W stage (32'h0 = nop/bubble)
//  ALUResult_W  in   32  ALU result / effective address from MEM/WB
//  pc8_W        in   32  PC+8 of the W instruction (link value)
//  DM_RD_W      in   32  raw aligned word read from data memory
//  A1           in   5   read address port 1 (D stage rs)
//  A2           in   5   read address port 2 (D stage rt)
//  RD1          out  32  read data port 1
//  RD2          out  32  read data port 2
//  WB_A3        out  5   destination register of W instr (0 if no write)
//  WB_WD        out  32  write-back data of W instr
//  WB_WE        out  1   1 when W instr writes a nonzero register
//  retired      out  CNT_W  count of non-nop instructions that passed W
// BEHAVIOUR
//  Decode (op = IR_W[31:26], funct = IR_W[5:0]):
//   - R-type op=0 with funct 0x21 addu / 0x23 subu: A3=rd, WD=ALUResult_W.
//   - R-type op=0 with funct 0x09 jalr: A3=rd, WD=pc8_W.
//   - R-type op=0 with funct 0x08 jr: no write.
//   - op 0x0D ori / 0x0F lui: A3=rt, WD=ALUResult_W.
//   - op 0x03 jal: A3=31, WD=pc8_W.
//   - op 0x23 lw: A3=rt, WD=DM_RD_W.
//   - op 0x20 lb / 0x24 lbu: A3=rt, WD=byte DM_RD_W[8*ALUResult_W[1:0]+:8],
//     sign- or zero-extended respectively.
//   - op 0x21 lh / 0x25 lhu: A3=rt, WD=half DM_RD_W[16*ALUResult_W[1]+:16],
//     sign- or zero-extended respectively.
//   - All other encodings (sw, beq, nop, unknown): no write, A3=0, WD=0.
//  WB_WE = write-class && A3!=0. WB_A3/WB_WD/WB_WE are combinational from IR_W.
//  GRF write: at posedge clk when WB_WE, reg[WB_A3] <= WB_WD. reg[0] is never written.
//  Read: RDn = (An==0) ? 0 : (WB_WE && An==WB_A3) ? WB_WD : reg[An].
//   - Combinational, so D sees the W value in the same cycle.
//  retired: +1 at posedge when IR_W != 0; wraps modulo 2^CNT_W.
//  Reset (reset==0, asynchronous):
//   - All registers and retired clear to 0 immediately; writes are blocked while low.
//   - Reads return 0 while low, except the bypass path still reflects the current IR_W.
//   - Release takes effect at the next posedge.
//  A reset mid-stream discards that cycle's write; no partial state is kept.
//  Halfword access with ALUResult_W[0]=1 is undefined (no trap); the selection rule above is still applied.
// TESTING
//  1. reset=0 then 1; read A1=5,A2=31 -> RD1=RD2=0, retired=0.
//  2. IR_W=ori $8 (0x3408_xxxx), ALUResult_W=0x0000_1234; same cycle A1=8
//     -> RD1=0x1234 (bypass); next cycle RD1=0x1234 from GRF; retired=1.
//  3. IR_W=lb $9, DM_RD_W=0x80FF_7F01, ALUResult_W[1:0]=3 -> $9=0xFFFF_FF80;
//     same with lbu -> 0x0000_0080; lhu at offset 2 -> 0x0000_80FF.
//  4. IR_W=jal, pc8_W=0x0000_3008 -> $31=0x3008; jalr rd=0 -> WB_WE=0, reg0 stays 0.
//  5. IR_W=addu $0,... ALUResult=0xDEAD -> WB_WE=0, RD1(A1=0)=0; sw/beq -> no GRF change.
//  6. Write $4=0xAAAA, assert reset async mid-cycle -> RD1(A1=4)=0 at once, no write at that edge.

Source files
------------

// File: rtl/wb_stage_grf_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_grf_if
// Description : Signal bundle between the MEM/WB pipeline register, the
//               decode stage and the writeback/register-file block.
//               master : drives W-stage inputs and D-stage read addresses
//               slave  : the wb_stage_grf block
//   IR_W/ALUResult_W/pc8_W/DM_RD_W : W-stage instruction and data
//   A1/A2 -> RD1/RD2               : D-stage register read ports
//   WB_A3/WB_WD/WB_WE              : W-stage write triple for forwarding
//   retired                        : retired-instruction counter
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_stage_grf_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      IR_W;
  logic [31:0]      ALUResult_W;
  logic [31:0]      pc8_W;
  logic [31:0]      DM_RD_W;
  logic [4:0]       A1;
  logic [4:0]       A2;
  logic [31:0]      RD1;
  logic [31:0]      RD2;
  logic [4:0]       WB_A3;
  logic [31:0]      WB_WD;
  logic             WB_WE;
  logic [CNT_W-1:0] retired;

  modport master (
    output IR_W, ALUResult_W, pc8_W, DM_RD_W, A1, A2,
    input  RD1, RD2, WB_A3, WB_WD, WB_WE, retired
  );

  modport slave (
    input  IR_W, ALUResult_W, pc8_W, DM_RD_W, A1, A2,
    output RD1, RD2, WB_A3, WB_WD, WB_WE, retired
  );
endinterface
`default_nettype wire

// File: rtl/wb_stage_grf.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_grf
// Description : MIPS writeback stage and 32x32 general register file.
//               Decodes the W-stage instruction, extends sub-word loads,
//               writes the GRF, serves two read ports with same-cycle
//               write bypass and counts retired (non-nop) instructions.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-low reset
//               bus   - wb_stage_grf_if.slave (W inputs, read ports,
//                       W write triple, retire counter)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage_grf #(
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  wire logic          clk,
  input  wire logic          reset,
  wb_stage_grf_if.slave      bus
);

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_JAL   = 6'h03;
  localparam logic [5:0] c_OP_ORI   = 6'h0D;
  localparam logic [5:0] c_OP_LUI   = 6'h0F;
  localparam logic [5:0] c_OP_LB    = 6'h20;
  localparam logic [5:0] c_OP_LH    = 6'h21;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_LBU   = 6'h24;
  localparam logic [5:0] c_OP_LHU   = 6'h25;
  localparam logic [5:0] c_FN_JALR  = 6'h09;
  localparam logic [5:0] c_FN_ADDU  = 6'h21;
  localparam logic [5:0] c_FN_SUBU  = 6'h23;

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_write;
  logic [4:0]  w_a3;
  logic [31:0] w_wd;
  logic        w_we;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;

  logic [31:0]      r_grf [NREG];
  logic [CNT_W-1:0] r_retired;

  // rs and shamt fields are not needed at writeback.
  logic w_unused;
  assign w_unused = &{1'b0, bus.IR_W[25:21], bus.IR_W[10:6]};

  assign w_op = bus.IR_W[31:26];
  assign w_fn = bus.IR_W[5:0];
  assign w_rt = bus.IR_W[20:16];
  assign w_rd = bus.IR_W[15:11];

  // Sub-word lane selection; a misaligned halfword still uses bit 1 only.
  assign w_byte = bus.DM_RD_W[{bus.ALUResult_W[1:0], 3'b000} +: 8];
  assign w_half = bus.ALUResult_W[1] ? bus.DM_RD_W[31:16] : bus.DM_RD_W[15:0];

  always_comb begin
    w_write = 1'b0;
    w_a3    = 5'd0;
    w_wd    = 32'd0;
    case (w_op)
      c_OP_RTYPE: begin
        if (w_fn == c_FN_ADDU || w_fn == c_FN_SUBU) begin
          w_write = 1'b1;
          w_a3    = w_rd;
          w_wd    = bus.ALUResult_W;
        end else if (w_fn == c_FN_JALR) begin
          w_write = 1'b1;
          w_a3    = w_rd;
          w_wd    = bus.pc8_W;
        end
      end
      c_OP_ORI, c_OP_LUI: begin
        w_write = 1'b1;
        w_a3    = w_rt;
        w_wd    = bus.ALUResult_W;
      end
      c_OP_JAL: begin
        w_write = 1'b1;
        w_a3    = 5'd31;
        w_wd    = bus.pc8_W;
      end
      c_OP_LW: begin
        w_write = 1'b1;
        w_a3    = w_rt;
        w_wd    = bus.DM_RD_W;
      end
      c_OP_LB, c_OP_LBU: begin
        w_write = 1'b1;
        w_a3    = w_rt;
        w_wd    = {{24{w_byte[7] & (w_op == c_OP_LB)}}, w_byte};
      end
      c_OP_LH, c_OP_LHU: begin
        w_write = 1'b1;
        w_a3    = w_rt;
        w_wd    = {{16{w_half[15] & (w_op == c_OP_LH)}}, w_half};
      end
      default: ;
    endcase
  end

  // Writes to register 0 are suppressed here so nothing downstream
  // (forwarding or the GRF) ever sees a write to the zero register.
  assign w_we = w_write && (w_a3 != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_grf[i] <= 32'd0;
      end
    end else if (w_we && (int'(w_a3) < NREG)) begin
      r_grf[w_a3] <= w_wd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retired <= '0;
    end else if (bus.IR_W != 32'd0) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Read ports: the bypass gives D the value being written this cycle,
  // which is why the GRF itself needs no write-before-read clocking.
  always_comb begin
    w_rd1 = 32'd0;
    if (bus.A1 == 5'd0) begin
      w_rd1 = 32'd0;
    end else if (w_we && (bus.A1 == w_a3)) begin
      w_rd1 = w_wd;
    end else if (int'(bus.A1) < NREG) begin
      w_rd1 = r_grf[bus.A1];
    end
  end

  always_comb begin
    w_rd2 = 32'd0;
    if (bus.A2 == 5'd0) begin
      w_rd2 = 32'd0;
    end else if (w_we && (bus.A2 == w_a3)) begin
      w_rd2 = w_wd;
    end else if (int'(bus.A2) < NREG) begin
      w_rd2 = r_grf[bus.A2];
    end
  end

  assign bus.RD1     = w_rd1;
  assign bus.RD2     = w_rd2;
  assign bus.WB_A3   = w_a3;
  assign bus.WB_WD   = w_wd;
  assign bus.WB_WE   = w_we;
  assign bus.retired = r_retired;

endmodule
`default_nettype wire
